// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and controller state encodings,
// plus the single/multi-cycle opcode classifier.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SRL   = 4'd3,
    ALU_SRA   = 4'd4,
    ALU_AND   = 4'd5,
    ALU_OR    = 4'd6,
    ALU_NOR   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_ROL   = 4'd10,
    ALU_ROR   = 4'd11,
    ALU_MULLO = 4'd12,
    ALU_MULHI = 4'd13,
    ALU_DIVU  = 4'd14,
    ALU_REMU  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_multicycle(alu_op_e op);
    return (op == ALU_MULLO) || (op == ALU_MULHI) ||
           (op == ALU_DIVU)  || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// cycle, with a down-counter that flags the final iteration on done_o.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             busy_q;
  alu_op_e          op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q;

  logic             is_div;
  logic             sel_hi;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  assign is_div = (op_q == ALU_DIVU) || (op_q == ALU_REMU);
  assign sel_hi = (op_q == ALU_MULHI) || (op_q == ALU_REMU);

  // hi holds the running product high word / partial remainder;
  // lo holds the multiplier bits still to consume / dividend-then-quotient.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        hi_d = div_diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = div_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done_o   = busy_q && (cnt_q == '0);
  assign result_o = sel_hi ? hi_d : lo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      op_q   <= ALU_MULLO;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      op_q   <= op_i;
      cnt_q  <= CNT_LAST;
      hi_q   <= '0;
      if ((op_i == ALU_DIVU) || (op_i == ALU_REMU)) begin
        lo_q   <= a_i;
        opnd_q <= b_i;
      end else begin
        lo_q   <= b_i;
        opnd_q <= a_i;
      end
    end else if (busy_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU for the execute stage: valid/ready request side, valid/yumi
// result side; single-cycle ops answer next cycle, mul/div go through BUSY.
//
// state | meaning
// IDLE  | no result held, ready for a request
// BUSY  | iterative mul/div in progress, requests ignored
// DONE  | result_o/flags_o valid, held until yumi_i
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] rd_i,
  input  logic [WIDTH-1:0] rs_i,
  output logic             valid_o,
  input  logic             yumi_i,
  output logic [WIDTH-1:0] result_o,
  output logic [1:0]       flags_o
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       flags_q, flags_d;

  alu_op_e          op;
  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  logic [SHAMT_W-1:0]   shamt;
  logic [2*WIDTH-1:0]   dbl;
  logic [SHAMT_W:0]     rol_idx;
  logic [WIDTH-1:0]     single_res;

  function automatic logic [1:0] flags_of(logic [WIDTH-1:0] r);
    return {r[WIDTH-1], (r == '0)};
  endfunction

  assign op      = alu_op_e'(op_i);
  assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_DONE) && yumi_i);
  assign accept  = valid_i && ready_o;

  // Rotates select a window out of the operand concatenated with itself, so
  // no shifter ever sees an amount of WIDTH.
  assign shamt   = rs_i[SHAMT_W-1:0];
  assign dbl     = {rd_i, rd_i};
  assign rol_idx = (SHAMT_W + 1)'(WIDTH) - {1'b0, shamt};

  always_comb begin
    single_res = '0;
    case (op)
      ALU_ADD:  single_res = rd_i + rs_i;
      ALU_SUB:  single_res = rd_i - rs_i;
      ALU_SLL:  single_res = rd_i << shamt;
      ALU_SRL:  single_res = rd_i >> shamt;
      ALU_SRA:  single_res = $unsigned($signed(rd_i) >>> shamt);
      ALU_AND:  single_res = rd_i & rs_i;
      ALU_OR:   single_res = rd_i | rs_i;
      ALU_NOR:  single_res = ~(rd_i | rs_i);
      ALU_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(rd_i) < $signed(rs_i))};
      ALU_SLTU: single_res = {{(WIDTH-1){1'b0}}, (rd_i < rs_i)};
      ALU_ROL:  single_res = dbl[rol_idx +: WIDTH];
      ALU_ROR:  single_res = dbl[{1'b0, shamt} +: WIDTH];
      default:  single_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    md_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (is_multicycle(op)) begin
            md_start = 1'b1;
            state_d  = ST_BUSY;
          end else begin
            state_d  = ST_DONE;
            result_d = single_res;
            flags_d  = flags_of(single_res);
          end
        end else if ((state_q == ST_DONE) && yumi_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          state_d  = ST_DONE;
          result_d = md_result;
          flags_d  = flags_of(md_result);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign valid_o  = (state_q == ST_DONE);
  assign result_o = result_q;
  assign flags_o  = flags_q;

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (md_start),
    .op_i     (op),
    .a_i      (rd_i),
    .b_i      (rs_i),
    .done_o   (md_done),
    .result_o (md_result)
  );

`ifndef SYNTHESIS
  a_yumi_needs_valid: assert property (@(posedge clk) disable iff (reset)
    yumi_i |-> valid_o);
  a_valid_held: assert property (@(posedge clk) disable iff (reset)
    (valid_o && !yumi_i) |=> valid_o);
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=32 (directed + random) and WIDTH=8 (random),
// scoreboard queues filled on accept and drained by per-instance monitors.
module tb_alu_seq;

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  flg;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, valid32, ready32, vout32, yumi32;
  logic [3:0]  op32;
  logic [31:0] rd32, rs32, res32;
  logic [1:0]  flg32;

  logic        rst8, valid8, ready8, vout8, yumi8;
  logic [3:0]  op8;
  logic [7:0]  rd8, rs8, res8;
  logic [1:0]  flg8;

  int   vectors = 0;
  int   miscompares = 0;
  bit   done8 = 1'b0;
  exp_t q32[$];
  exp_t q8[$];

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst32), .valid_i(valid32), .ready_o(ready32),
    .op_i(op32), .rd_i(rd32), .rs_i(rs32), .valid_o(vout32),
    .yumi_i(yumi32), .result_o(res32), .flags_o(flg32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .valid_i(valid8), .ready_o(ready8),
    .op_i(op8), .rd_i(rd8), .rs_i(rs8), .valid_o(vout8),
    .yumi_i(yumi8), .result_o(res8), .flags_o(flg8)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Reference: plain integer arithmetic at width w (w <= 32).
  function automatic logic [63:0] ref_alu(input int op, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input int w);
    logic [63:0] mask, a, b, r;
    longint sa, sb;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    sh = int'(b % 64'(w));
    sa = a[w-1] ? (a | ~mask) : a;
    sb = b[w-1] ? (b | ~mask) : b;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a << sh;
      3:  r = a >> sh;
      4:  r = sa >>> sh;
      5:  r = a & b;
      6:  r = a | b;
      7:  r = ~(a | b);
      8:  r = (sa < sb) ? 64'd1 : 64'd0;
      9:  r = (a < b) ? 64'd1 : 64'd0;
      10: r = (sh == 0) ? a : ((a << sh) | (a >> (w - sh)));
      11: r = (sh == 0) ? a : ((a >> sh) | (a << (w - sh)));
      12: r = a * b;
      13: r = (a * b) >> w;
      14: r = (b == 0) ? mask : a / b;
      15: r = (b == 0) ? a : a % b;
      default: r = 64'd0;
    endcase
    return r & mask;
  endfunction

  function automatic exp_t mk_exp(input logic [63:0] r, input int w);
    exp_t e;
    e.res = r[31:0];
    e.flg = {r[w-1], (r == 64'd0)};
    return e;
  endfunction

  function automatic logic [31:0] rnd_opnd(input int w);
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 15));
      3: return 32'h1 << (w - 1);
      default: return $urandom;
    endcase
  endfunction

  // Monitors: pop and compare whenever a result is handed over.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst32 && vout32 && yumi32) begin
        if (q32.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL w32_unexpected: got result %h, required no output", res32);
        end else begin
          e = q32.pop_front();
          check("w32_result", 64'(res32), 64'(e.res));
          check("w32_flags", 64'(flg32), 64'(e.flg));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst8 && vout8 && yumi8) begin
        if (q8.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL w8_unexpected: got result %h, required no output", res8);
        end else begin
          e = q8.pop_front();
          check("w8_result", 64'(res8), 64'(e.res[7:0]));
          check("w8_flags", 64'(flg8), 64'(e.flg));
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want, input bit with_yumi);
    exp_t e;
    op32 = op; rd32 = a; rs32 = b; valid32 = 1'b1; yumi32 = with_yumi;
    #1;
    check("accept_ready", 64'(ready32), 64'd1);
    if (ready32) begin
      e.res = want;
      e.flg = {want[31], (want == 32'd0)};
      q32.push_back(e);
    end
    @(negedge clk);
    valid32 = 1'b0; yumi32 = 1'b0;
    rd32 = $urandom; rs32 = $urandom;
  endtask

  task automatic wait_valid(input int want_lat, input bit pulse);
    int lat;
    bit busy_ok;
    lat = 1;
    busy_ok = 1'b1;
    while (!vout32 && lat < 60) begin
      if (ready32) busy_ok = 1'b0;
      valid32 = pulse && (lat >= 3) && (lat <= 5);
      op32 = 4'd0;
      @(negedge clk);
      lat++;
    end
    valid32 = 1'b0;
    check("latency", 64'(lat), 64'(want_lat));
    if (want_lat > 1) check("busy_not_ready", 64'(busy_ok), 64'd1);
  endtask

  task automatic take();
    yumi32 = 1'b1;
    @(negedge clk);
    yumi32 = 1'b0;
    check("valid_drop_after_yumi", 64'(vout32), 64'd0);
  endtask

  task automatic run_dir(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input bit pulse);
    issue(op, a, b, want, 1'b0);
    wait_valid((op >= 4'd12) ? 33 : 1, pulse);
    take();
  endtask

  initial begin
    int n;
    logic [63:0] r;
    rst32 = 1'b1; valid32 = 1'b0; yumi32 = 1'b0; op32 = '0; rd32 = '0; rs32 = '0;
    repeat (2) @(negedge clk);
    rst32 = 1'b0;
    check("reset_valid", 64'(vout32), 64'd0);
    check("reset_ready", 64'(ready32), 64'd1);
    check("reset_result", 64'(res32), 64'd0);
    check("reset_flags", 64'(flg32), 64'd0);

    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    wait_valid(1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 64'(vout32), 64'd1);
      check("hold_result", 64'(res32), 64'd0);
      check("hold_flags", 64'(flg32), 64'd1);
      @(negedge clk);
    end
    issue(4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1);
    wait_valid(1, 1'b0);
    take();

    run_dir(4'd10, 32'h8000_0001, 32'd1,  32'h0000_0003, 1'b0);
    run_dir(4'd11, 32'h8000_0001, 32'd4,  32'h1800_0000, 1'b0);
    run_dir(4'd10, 32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, 1'b0);
    run_dir(4'd11, 32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 1'b0);
    run_dir(4'd4,  32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
    run_dir(4'd8,  32'h8000_0000, 32'd1,  32'd1,         1'b0);
    run_dir(4'd9,  32'h8000_0000, 32'd1,  32'd0,         1'b0);
    run_dir(4'd7,  32'd0,         32'd0,  32'hFFFF_FFFF, 1'b0);
    run_dir(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_dir(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_dir(4'd14, 32'd100,       32'd7,  32'd14,        1'b1);
    run_dir(4'd15, 32'd100,       32'd7,  32'd2,         1'b0);
    run_dir(4'd14, 32'h1234,      32'd0,  32'hFFFF_FFFF, 1'b0);
    run_dir(4'd15, 32'h1234,      32'd0,  32'h1234,      1'b0);

    issue(4'd14, 32'd50, 32'd3, 32'd16, 1'b0);
    repeat (10) @(negedge clk);
    rst32 = 1'b1;
    @(negedge clk);
    rst32 = 1'b0;
    q32.delete();
    check("midop_reset_valid", 64'(vout32), 64'd0);
    check("midop_reset_ready", 64'(ready32), 64'd1);
    check("midop_reset_result", 64'(res32), 64'd0);
    run_dir(4'd0, 32'd2, 32'd3, 32'd5, 1'b0);

    for (int c = 0; c < 700; c++) begin
      yumi32  = vout32 ? ($urandom_range(0, 3) != 0) : 1'b0;
      valid32 = ($urandom_range(0, 2) != 0);
      op32    = 4'($urandom_range(0, 15));
      rd32    = rnd_opnd(32);
      rs32    = rnd_opnd(32);
      #1;
      if (valid32 && ready32) begin
        r = ref_alu(int'(op32), 64'(rd32), 64'(rs32), 32);
        q32.push_back(mk_exp(r, 32));
      end
      @(negedge clk);
    end
    valid32 = 1'b0;
    n = 0;
    while (q32.size() != 0 && n < 100) begin
      yumi32 = vout32;
      @(negedge clk);
      n++;
    end
    yumi32 = 1'b0;
    check("w32_drain_left", 64'(q32.size()), 64'd0);

    n = 0;
    while (!done8 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("w8_finished", 64'(done8), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int n;
    logic [31:0] ta, tb;
    logic [63:0] r;
    rst8 = 1'b1; valid8 = 1'b0; yumi8 = 1'b0; op8 = '0; rd8 = '0; rs8 = '0;
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    for (int c = 0; c < 900; c++) begin
      yumi8  = vout8 ? ($urandom_range(0, 2) != 0) : 1'b0;
      valid8 = ($urandom_range(0, 3) != 0);
      op8    = 4'($urandom_range(0, 15));
      ta     = rnd_opnd(8);
      tb     = rnd_opnd(8);
      rd8    = ta[7:0];
      rs8    = tb[7:0];
      #1;
      if (valid8 && ready8) begin
        r = ref_alu(int'(op8), 64'(rd8), 64'(rs8), 8);
        q8.push_back(mk_exp(r, 8));
      end
      @(negedge clk);
    end
    valid8 = 1'b0;
    n = 0;
    while (q8.size() != 0 && n < 100) begin
      yumi8 = vout8;
      @(negedge clk);
      n++;
    end
    yumi8 = 1'b0;
    check("w8_drain_left", 64'(q8.size()), 64'd0);
    done8 = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required summary before 90000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
